// File: rtl/alu_mdu.sv
// alu_mdu: RV base integer ALU plus iterative M-extension multiply/divide behind valid/ready handshakes
// ports: clk_w_i, rst_w_i_l (async active-low), flush_w_i_h aborts any op;
//   request  req_valid_w_i_h/req_ready_w_o_h carrying a_data_w_i, b_data_w_i, alu_control_w_i;
//   response resp_valid_w_o_h/resp_ready_w_i_h carrying alu_res_w_o, zero_w_o_h, illegal_w_o_h.
// define ALU_MDU_DIV_EN to build DIV/DIVU/REM/REMU; without it those opcodes respond as illegal.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_l,
  input  logic            flush_w_i_h,
  input  logic            req_valid_w_i_h,
  output logic            req_ready_w_o_h,
  input  logic [XLEN-1:0] a_data_w_i,
  input  logic [XLEN-1:0] b_data_w_i,
  input  logic [4:0]      alu_control_w_i,
  output logic            resp_valid_w_o_h,
  input  logic            resp_ready_w_i_h,
  output logic [XLEN-1:0] alu_res_w_o,
  output logic            zero_w_o_h,
  output logic            illegal_w_o_h
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW:0] NITER = XLEN[SHW:0];
  localparam logic [SHW:0] LAST = {{SHW{1'b0}}, 1'b1};
`ifdef ALU_MDU_DIV_EN
  localparam logic DIV_EN = 1'b1;
  logic [XLEN:0] rs, diff;
`else
  localparam logic DIV_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [SHW:0] cnt;
  logic [XLEN-1:0] hi, lo, dsr, nhi, nlo, fin, base, spec, am, bm;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0] sum;
  logic [2:0] op_r;
  logic neg_r, neg, sa, sb, is_m, legal, special;
  logic [4:0] op;
  logic [SHW-1:0] sh;
  assign op = alu_control_w_i;
  assign sh = b_data_w_i[SHW-1:0];
  assign req_ready_w_o_h = state == IDLE && !flush_w_i_h;
  assign resp_valid_w_o_h = state == DONE;
  assign zero_w_o_h = alu_res_w_o == '0;
  always_comb begin
    case (op)
      5'b00000: base = a_data_w_i + b_data_w_i;
      5'b00001: base = a_data_w_i << sh;
      5'b00010: base = {{(XLEN-1){1'b0}}, $signed(a_data_w_i) < $signed(b_data_w_i)};
      5'b00011: base = {{(XLEN-1){1'b0}}, a_data_w_i < b_data_w_i};
      5'b00100: base = a_data_w_i ^ b_data_w_i;
      5'b00101: base = a_data_w_i >> sh;
      5'b00110: base = a_data_w_i | b_data_w_i;
      5'b00111: base = a_data_w_i & b_data_w_i;
      5'b01000: base = a_data_w_i - b_data_w_i;
      5'b01101: base = $signed(a_data_w_i) >>> sh;
      default:  base = '0;
    endcase
  end
  // op[2] selects divide; op[0] marks the unsigned divide forms, op[1:0] the multiply signedness
  always_comb begin
    is_m = op[4:3] == 2'b10;
    legal = (!op[4] && (!op[3] || op[2:0] == 3'b000 || op[2:0] == 3'b101)) || (is_m && (!op[2] || DIV_EN));
    sa = a_data_w_i[XLEN-1] && (op[2] ? !op[0] : op[1:0] != 2'b11);
    sb = b_data_w_i[XLEN-1] && (op[2] ? !op[0] : !op[1]);
    neg = op[2] && op[1] ? sa : sa ^ sb;
    am = sa ? -a_data_w_i : a_data_w_i;
    bm = sb ? -b_data_w_i : b_data_w_i;
    special = op[2] ? (b_data_w_i == '0 || (!op[0] && a_data_w_i == MIN && b_data_w_i == '1))
                    : (a_data_w_i == '0 || b_data_w_i == '0);
    spec = !op[2] ? '0 : b_data_w_i == '0 ? (op[1] ? a_data_w_i : '1) : (op[1] ? '0 : a_data_w_i);
  end
  // multiply: {hi,lo} shifts right, lo holds the multiplier; divide: {hi,lo} shifts left, hi is the remainder
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
    nhi = sum[XLEN:1];
    nlo = {sum[0], lo[XLEN-1:1]};
    prod = {nhi, nlo};
    prod = neg_r ? -prod : prod;
    fin = op_r == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
    rs = {hi, lo[XLEN-1]};
    diff = rs - {1'b0, dsr};
    if (op_r[2]) begin
      nhi = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
      nlo = {lo[XLEN-2:0], !diff[XLEN]};
      fin = op_r[1] ? (neg_r ? -nhi : nhi) : (neg_r ? -nlo : nlo);
    end
`endif
  end
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      dsr <= '0;
      op_r <= '0;
      neg_r <= 1'b0;
      alu_res_w_o <= '0;
      illegal_w_o_h <= 1'b0;
    end else if (flush_w_i_h) state <= IDLE;
    else case (state)
      IDLE: if (req_valid_w_i_h) begin
        illegal_w_o_h <= !legal;
        alu_res_w_o <= !legal ? '0 : !is_m ? base : spec;
        state <= legal && is_m && !special ? CALC : DONE;
        cnt <= NITER;
        hi <= '0;
        lo <= op[2] ? am : bm;
        dsr <= op[2] ? bm : am;
        op_r <= op[2:0];
        neg_r <= neg;
      end
      CALC: begin
        hi <= nhi;
        lo <= nlo;
        cnt <= cnt - LAST;
        if (cnt == LAST) begin
          alu_res_w_o <= fin;
          state <= DONE;
        end
      end
      DONE: if (resp_ready_w_i_h) state <= IDLE;
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checks of alu_mdu against an arithmetic reference model
module tb_alu_mdu;
`ifdef ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_l, flush, req_valid, req_ready, resp_valid, resp_ready, zero, ill;
  logic [31:0] a_data, b_data, res;
  logic [4:0] ctrl;
  int checks = 0, errors = 0;
  typedef struct {logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp;} plan_t;
  plan_t plan[$];
  always #5 clk = ~clk;
  alu_mdu #(.XLEN(32)) dut (
    .clk_w_i(clk), .rst_w_i_l(rst_l), .flush_w_i_h(flush),
    .req_valid_w_i_h(req_valid), .req_ready_w_o_h(req_ready),
    .a_data_w_i(a_data), .b_data_w_i(b_data), .alu_control_w_i(ctrl),
    .resp_valid_w_o_h(resp_valid), .resp_ready_w_i_h(resp_ready),
    .alu_res_w_o(res), .zero_w_o_h(zero), .illegal_w_o_h(ill)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic il, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int si, ti;
    bit sgn, rem;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b; si = a; ti = b;
    r = '0; il = 1'b0; lat = 1;
    sgn = !op[0]; rem = op[1];
    case (op)
      5'd0: r = a + b;
      5'd1: r = a << b[4:0];
      5'd2: r = {31'b0, si < ti};
      5'd3: r = {31'b0, a < b};
      5'd4: r = a ^ b;
      5'd5: r = a >> b[4:0];
      5'd6: r = a | b;
      5'd7: r = a & b;
      5'd8: r = a - b;
      5'd13: r = si >>> b[4:0];
      5'd16, 5'd17, 5'd18, 5'd19: begin
        p = op[1:0] <= 2'd1 ? sa * sb : op[1:0] == 2'd2 ? sa * ub : ua * ub;
        r = op[1:0] == 2'd0 ? p[31:0] : p[63:32];
        lat = (a == 0 || b == 0) ? 1 : 33;
      end
      5'd20, 5'd21, 5'd22, 5'd23:
        if (!DIV_EN) il = 1'b1;
        else if (b == 0) r = rem ? a : 32'hFFFF_FFFF;
        else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = rem ? 32'd0 : a;
        else begin
          lat = 33;
          if (sgn) r = rem ? si % ti : si / ti;
          else r = rem ? a % b : a / b;
        end
      default: il = 1'b1;
    endcase
  endfunction
  task automatic accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("ready_timeout", 64'(w), 64'd0);
    req_valid = 1'b1; ctrl = op; a_data = a; b_data = b;
    if (hold) resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; ctrl = 5'($urandom); a_data = $urandom; b_data = $urandom;
  endtask
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] got);
    logic [31:0] er;
    logic eil;
    int elat, lat;
    model(op, a, b, er, eil, elat);
    accept(op, a, b, hold > 0);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got = res;
    check("latency", 64'(lat), 64'(elat));
    check("result", 64'(res), 64'(er));
    check("illegal", 64'(ill), 64'(eil));
    check("zero", 64'(zero), 64'(er == 0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", 64'(res), 64'(er));
      check("hold_ready", 64'(req_ready), 64'd0);
      check("hold_valid", 64'(resp_valid), 64'd1);
    end
    resp_ready = 1'b1;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] got;
    logic [4:0] op;
    int seen;
    rst_l = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    ctrl = '0; a_data = '0; b_data = '0;
    #1 rst_l = 1'b0;
    #2;
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_illegal", 64'(ill), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    plan.push_back('{5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000});
    plan.push_back('{5'd8, 32'd5, 32'd5, 32'd0});
    plan.push_back('{5'd13, 32'h8000_0000, 32'h21, 32'hC000_0000});
    plan.push_back('{5'd1, 32'h1, 32'h20, 32'h1});
    plan.push_back('{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1});
    plan.push_back('{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});
    plan.push_back('{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    plan.push_back('{5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    plan.push_back('{5'd31, 32'h1234, 32'h5678, 32'h0});
`ifdef ALU_MDU_DIV_EN
    plan.push_back('{5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    plan.push_back('{5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    plan.push_back('{5'd21, 32'd7, 32'd0, 32'hFFFF_FFFF});
    plan.push_back('{5'd23, 32'd7, 32'd0, 32'd7});
    plan.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    plan.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
`else
    plan.push_back('{5'd21, 32'd9, 32'd3, 32'd0});
`endif
    foreach (plan[i]) begin
      do_op(plan[i].op, plan[i].a, plan[i].b, 0, got);
      check($sformatf("plan%0d", i), 64'(got), 64'(plan[i].exp));
    end
    do_op(5'd0, 32'd3, 32'd4, 5, got);
    accept(5'd16, 32'd3, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'(req_ready), 64'd1);
    check("flush_valid", 64'(resp_valid), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("flush_noresp", 64'(seen), 64'd0);
    flush = 1'b1; req_valid = 1'b1; ctrl = 5'd0; a_data = 32'd1; b_data = 32'd1;
    @(posedge clk);
    #1 begin flush = 1'b0; req_valid = 1'b0; end
    @(negedge clk);
    check("flushreq_valid", 64'(resp_valid), 64'd0);
    check("flushreq_ready", 64'(req_ready), 64'd1);
    do_op(5'd0, 32'd1, 32'd2, 0, got);
    accept(5'd20, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_res", 64'(res), 64'd0);
    check("mid_rst_zero", 64'(zero), 64'd1);
    check("mid_rst_illegal", 64'(ill), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_l = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("mid_rst_noresp", 64'(seen), 64'd0);
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 1) ? 5'($urandom_range(16, 23)) : 5'($urandom_range(0, 31));
      do_op(op, pick(), pick(), 0, got);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the single-cycle RV32 ALU. It executes the RV base integer ops and the M-extension multiply/divide ops over an XLEN-bit datapath, behind valid/ready request and response handshakes. Base ops complete in one cycle. MUL/DIV use a shared iterative shift-add / restoring engine. The block sits in the execute stage; the pipeline stalls on `req_ready_w_o_h`/`resp_valid_w_o_h`.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; must be a power of two, ≥ 8.
- `SHW` (localparam) = $clog2(XLEN): shift-amount width.

Ports:
- `clk_w_i` in 1: clock; all state updates on the rising edge.
- `rst_w_i_l` in 1: reset, asynchronous, active-low.
- `flush_w_i_h` in 1: synchronous abort of any in-flight or pending op.
- `req_valid_w_i_h` in 1: request valid.
- `req_ready_w_o_h` out 1: block can accept a request.
- `a_data_w_i` in XLEN: operand A (rs1).
- `b_data_w_i` in XLEN: operand B (rs2/imm).
- `alu_control_w_i` in 5: opcode, sampled at accept.
- `resp_valid_w_o_h` out 1: result valid.
- `resp_ready_w_i_h` in 1: consumer takes result.
- `alu_res_w_o` out XLEN: registered result.
- `zero_w_o_h` out 1: `alu_res_w_o == 0`.
- `illegal_w_o_h` out 1: the accepted opcode was illegal or is compiled out.

## Operation
- Opcodes:
  - Base: 00000 ADD, 00001 SLL, 00010 SLT, 00011 SLTU, 00100 XOR, 00101 SRL, 00110 OR, 00111 AND, 01000 SUB, 01101 SRA.
  - M-extension: 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - All other codes are illegal.
- Shifts use only `b[SHW-1:0]`; upper bits of B are ignored.
- SLT/SLTU write 1 or 0, zero-extended.
- FSM states:
  - IDLE: `req_ready_w_o_h` = 1 when `!flush_w_i_h`.
    - Accepting a base, illegal, or special-case op → DONE.
    - Accepting a MUL/DIV op that is not a special case → CALC, with iteration counter = XLEN.
  - CALC: one iteration per cycle on operand magnitudes. The sign of the result is corrected on the final iteration. Counter reaches 0 → DONE.
  - DONE: `resp_valid_w_o_h` = 1. `resp_ready_w_i_h` → IDLE.
- MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits with signed×signed, signed×unsigned, and unsigned×unsigned operands respectively.
- Special cases are resolved in one cycle with no CALC:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow (A = most-negative, B = −1): DIV → A; REM → 0.
  - Either multiply operand 0: result 0.
- Signed remainder takes the sign of the dividend. Quotient truncates toward zero.
- Illegal opcode: one-cycle response, `alu_res_w_o` = 0, `illegal_w_o_h` = 1.
- Flush: any state → IDLE on the next edge with no response; `resp_valid_w_o_h` drops. Flush has priority over an accept in the same cycle.

## Timing
- Reset values: `resp_valid_w_o_h`=0, `alu_res_w_o`=0, `zero_w_o_h`=1, `illegal_w_o_h`=0, state IDLE, so `req_ready_w_o_h`=1.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- Accept occurs at edge E when `req_valid_w_i_h && req_ready_w_o_h`.
- Latency:
  - Base, illegal, and special-case ops: `resp_valid_w_o_h` high after edge E+1.
  - Iterative ops: `resp_valid_w_o_h` high after edge E+XLEN+1.
- Throughput: one op per 2 cycles at best. There is no accept while in DONE.
- While `resp_valid_w_o_h && !resp_ready_w_i_h`: the result, zero, and illegal outputs are held stable and `req_ready_w_o_h`=0.
- Operands and opcode are captured at accept; changes to the inputs afterwards are ignored.

## Configuration
- `ALU_MDU_DIV_EN` defined:
  - DIV/DIVU/REM/REMU are implemented as above.
- `ALU_MDU_DIV_EN` undefined:
  - The divider datapath is removed.
  - Opcodes 10100–10111 are treated as illegal: one-cycle response, result 0, `illegal_w_o_h`=1.
  - Multiply is always present.

## Test plan
Run with XLEN=32 and `ALU_MDU_DIV_EN` defined.
- ADD 0x7FFFFFFF + 0x1 → 0x80000000, zero=0, `resp_valid_w_o_h` 1 cycle after accept. SUB 5−5 → 0, zero=1.
- SRA 0x80000000 by B=0x00000021 → 0xC0000000 (shift 1). SLL 0x1 by B=0x20 → 0x1.
- Operands 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL → 0x1; MULH → 0x0; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
  - Each response arrives exactly 33 cycles after accept.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF, each at 33 cycles.
  - DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7, each at 1 cycle.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each at 1 cycle.
- Backpressure and flush:
  - Hold `resp_ready_w_i_h` low for 5 cycles: result stays stable and `req_ready_w_o_h`=0 throughout.
  - Assert flush at CALC cycle 10 of a MUL: no response, `req_ready_w_o_h`=1 the next cycle.
  - Assert flush together with `req_valid_w_i_h`: the request is not accepted.
- Reset and illegal opcode:
  - Drop `rst_w_i_l` mid-DIV: all outputs return to reset values before the next edge.
  - Opcode 11111 → result 0, `illegal_w_o_h`=1, latency 1.
  - Rebuild without `ALU_MDU_DIV_EN`: DIVU 9/3 → 0 with `illegal_w_o_h`=1.
